// File: rtl/l2sw_pkg.sv
// Shared constants for the receive monitor: frame layout, MAC map, display FSM encoding.
package l2sw_pkg;

  localparam logic [3:0] SFD   = 4'b0101;
  localparam logic [3:0] MAC_A = 4'hA;
  localparam logic [3:0] MAC_B = 4'hB;
  localparam logic [3:0] MAC_C = 4'hC;
  localparam logic [3:0] MAC_D = 4'hD;

  localparam int SFD_HI = 15;
  localparam int SFD_LO = 12;
  localparam int DST_HI = 11;
  localparam int DST_LO = 8;
  localparam int SRC_HI = 7;
  localparam int SRC_LO = 4;
  localparam int PAY_HI = 3;
  localparam int PAY_LO = 0;

  // log entry = {port[1:0], DST, SRC, PAYLOAD}
  localparam int LOG_W = 14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_HOLD = 2'd2
  } disp_state_t;

  function automatic logic [3:0] port_mac(input logic [1:0] p);
    case (p)
      2'd0:    port_mac = MAC_A;
      2'd1:    port_mac = MAC_B;
      2'd2:    port_mac = MAC_C;
      default: port_mac = MAC_D;
    endcase
  endfunction

endpackage

// File: rtl/rx_frame_monitor_if.sv
// Receive-side and display-side signal bundle of rx_frame_monitor.
// Error-count signals exist only when RX_MONITOR_ERR_CNT_EN is defined.
interface rx_frame_monitor_if #(
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 4
);
  logic                            clear;
  logic [NUM_PORTS*16-1:0]         rx_frame;
  logic [NUM_PORTS-1:0]            rx_valid;
  logic                            disp_valid;
  logic [1:0]                      disp_port;
  logic [3:0]                      disp_dst;
  logic [3:0]                      disp_src;
  logic [3:0]                      disp_payload;
  logic [$clog2(FIFO_DEPTH):0]     log_count;
  logic                            overflow;
`ifdef RX_MONITOR_ERR_CNT_EN
  logic [7:0]                      err_sfd_cnt;
  logic [7:0]                      err_dst_cnt;

  modport slave (
    input  clear, rx_frame, rx_valid,
    output disp_valid, disp_port, disp_dst, disp_src, disp_payload,
           log_count, overflow, err_sfd_cnt, err_dst_cnt
  );
  modport master (
    output clear, rx_frame, rx_valid,
    input  disp_valid, disp_port, disp_dst, disp_src, disp_payload,
           log_count, overflow, err_sfd_cnt, err_dst_cnt
  );
`else
  modport slave (
    input  clear, rx_frame, rx_valid,
    output disp_valid, disp_port, disp_dst, disp_src, disp_payload,
           log_count, overflow
  );
  modport master (
    output clear, rx_frame, rx_valid,
    input  disp_valid, disp_port, disp_dst, disp_src, disp_payload,
           log_count, overflow
  );
`endif
endinterface

// File: rtl/rx_log_fifo.sv
// Synchronous FIFO for accepted frames; DEPTH must be a power of two >= 2.
module rx_log_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // a pop frees the slot the same-cycle push needs
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rx_frame_monitor.sv
// Captures end-device rx frames, filters them by SFD/DST, logs and shows one at a time.
// Define RX_MONITOR_ERR_CNT_EN to add per-cause rejected-frame counters.
//
//   state   | meaning
//   --------+------------------------------------------------
//   ST_IDLE | nothing displayed, waiting for a logged frame
//   ST_SHOW | frame on display, dwell counter running
//   ST_HOLD | dwell expired, last frame kept until next one
module rx_frame_monitor
  import l2sw_pkg::*;
#(
  parameter int         NUM_PORTS    = 4,
  parameter int         FIFO_DEPTH   = 4,
  parameter int         DWELL_CYCLES = 50_000_000,
  parameter logic [3:0] MAC_BASE     = MAC_A
) (
  input  logic               clk,
  input  logic               rst,
  rx_frame_monitor_if.slave  mon
);
  localparam int PW      = $clog2(NUM_PORTS);
  localparam int DWELL_W = $clog2(DWELL_CYCLES);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  disp_state_t            state, state_nx;
  logic [DWELL_W-1:0]     dwell;
  logic [NUM_PORTS-1:0]   rx_valid_d1;
  logic [NUM_PORTS-1:0]   rx_edge;
  logic [NUM_PORTS-1:0]   pend;
  logic [15:0]            pend_frame [NUM_PORTS];
  logic [PW-1:0]          rr_ptr;
  logic [NUM_PORTS-1:0]   grant;
  logic                   grant_any;
  logic [PW-1:0]          grant_idx;
  logic [PW-1:0]          cand;
  logic [15:0]            grant_frame;
  logic                   sfd_ok;
  logic                   dst_ok;
  logic                   accept;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [LOG_W-1:0]       fifo_rdata;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_drop;
  logic [1:0]             disp_port;
  logic [3:0]             disp_dst;
  logic [3:0]             disp_src;
  logic [3:0]             disp_pay;
  logic                   overflow;

  assign rx_edge = mon.rx_valid & ~rx_valid_d1;

  // round-robin: search starts at rr_ptr, which points one past the last grant
  always_comb begin
    grant_any = 1'b0;
    grant_idx = rr_ptr;
    grant     = '0;
    cand      = rr_ptr;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = rr_ptr + PW'(i);
      if (!grant_any && pend[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign grant_frame = pend_frame[grant_idx];
  assign sfd_ok      = (grant_frame[SFD_HI:SFD_LO] == SFD);
  assign dst_ok      = (grant_frame[DST_HI:DST_LO] == MAC_BASE + 4'(grant_idx));
  assign accept      = grant_any && sfd_ok && dst_ok;
  assign fifo_push   = accept && !mon.clear;
  assign fifo_drop   = accept && fifo_full && !fifo_pop;

  rx_log_fifo #(
    .WIDTH (LOG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_log_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (mon.clear),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({2'(grant_idx), grant_frame[DST_HI:0]}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_nx = state;
    fifo_pop = 1'b0;
    unique case (state)
      ST_IDLE, ST_HOLD: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_nx = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (dwell == '0) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
          end else begin
            state_nx = ST_HOLD;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    if (mon.clear) begin
      fifo_pop = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      dwell       <= '0;
      disp_port   <= '0;
      disp_dst    <= '0;
      disp_src    <= '0;
      disp_pay    <= '0;
      rx_valid_d1 <= '0;
      pend        <= '0;
      rr_ptr      <= '0;
      overflow    <= 1'b0;
    end else if (mon.clear) begin
      state       <= ST_IDLE;
      dwell       <= '0;
      disp_port   <= '0;
      disp_dst    <= '0;
      disp_src    <= '0;
      disp_pay    <= '0;
      rx_valid_d1 <= mon.rx_valid;
      pend        <= '0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nx;
      rx_valid_d1 <= mon.rx_valid;
      // a same-cycle grant and edge leaves the new frame pending
      pend        <= (pend & ~grant) | rx_edge;
      if (grant_any) begin
        rr_ptr <= grant_idx + 1'b1;
      end
      if (fifo_pop) begin
        disp_port <= fifo_rdata[LOG_W-1:LOG_W-2];
        disp_dst  <= fifo_rdata[DST_HI:DST_LO];
        disp_src  <= fifo_rdata[SRC_HI:SRC_LO];
        disp_pay  <= fifo_rdata[PAY_HI:PAY_LO];
        dwell     <= DWELL_W'(DWELL_CYCLES - 1);
      end else if (dwell != '0) begin
        dwell <= dwell - 1'b1;
      end
      if ((|(rx_edge & pend & ~grant)) || fifo_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rx_edge[p]) begin
        pend_frame[p] <= mon.rx_frame[16*p +: 16];
      end
    end
  end

`ifdef RX_MONITOR_ERR_CNT_EN
  logic [7:0] err_sfd_cnt;
  logic [7:0] err_dst_cnt;

  // SFD errors mask DST errors; both counters saturate
  always_ff @(posedge clk) begin
    if (rst || mon.clear) begin
      err_sfd_cnt <= '0;
      err_dst_cnt <= '0;
    end else if (grant_any) begin
      if (!sfd_ok) begin
        if (err_sfd_cnt != 8'hFF) err_sfd_cnt <= err_sfd_cnt + 1'b1;
      end else if (!dst_ok) begin
        if (err_dst_cnt != 8'hFF) err_dst_cnt <= err_dst_cnt + 1'b1;
      end
    end
  end

  assign mon.err_sfd_cnt = err_sfd_cnt;
  assign mon.err_dst_cnt = err_dst_cnt;
`endif

  assign mon.disp_valid   = (state != ST_IDLE);
  assign mon.disp_port    = disp_port;
  assign mon.disp_dst     = disp_dst;
  assign mon.disp_src     = disp_src;
  assign mon.disp_payload = disp_pay;
  assign mon.log_count    = fifo_count;
  assign mon.overflow     = overflow;

endmodule

// File: tb/tb_rx_frame_monitor.sv
// Bench for rx_frame_monitor: queue-based reference model checked every cycle, plus literal pins.
module tb_rx_frame_monitor;
  localparam int         NP    = 4;
  localparam int         DEPTH = 4;
  localparam int         DWELL = 8;
  localparam logic [3:0] MAC0  = 4'hA;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rx_frame_monitor_if #(.NUM_PORTS(NP), .FIFO_DEPTH(DEPTH)) mon_if ();

  rx_frame_monitor #(
    .NUM_PORTS    (NP),
    .FIFO_DEPTH   (DEPTH),
    .DWELL_CYCLES (DWELL),
    .MAC_BASE     (MAC0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mon (mon_if)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: pending slot per port, log queue, remaining display cycles
  logic [15:0] m_pf   [NP];
  bit          m_pend [NP];
  bit          m_prev [NP];
  int          m_rr   = 0;
  logic [13:0] m_q    [$];
  int          m_rem  = 0;
  bit          m_vis  = 1'b0;
  logic [13:0] m_disp = '0;
  bit          m_ovf  = 1'b0;
  int          m_esfd = 0;
  int          m_edst = 0;

  always @(posedge clk) begin
    logic [NP-1:0] rxv;
    logic [15:0]   f;
    int            g;
    rxv = mon_if.rx_valid;
    if (rst || mon_if.clear) begin
      m_q.delete();
      m_rem  = 0;
      m_vis  = 1'b0;
      m_disp = '0;
      m_ovf  = 1'b0;
      m_esfd = 0;
      m_edst = 0;
      if (rst) m_rr = 0;
      for (int p = 0; p < NP; p++) begin
        m_pend[p] = 1'b0;
        m_prev[p] = rst ? 1'b0 : rxv[p];
      end
    end else begin
      if (m_rem > 1) m_rem--;
      else if (m_q.size() > 0) begin
        m_disp = m_q.pop_front();
        m_vis  = 1'b1;
        m_rem  = DWELL;
      end else m_rem = 0;
      g = -1;
      for (int k = 0; k < NP; k++)
        if (g < 0 && m_pend[(m_rr + k) % NP]) g = (m_rr + k) % NP;
      if (g >= 0) begin
        f         = m_pf[g];
        m_pend[g] = 1'b0;
        m_rr      = (g + 1) % NP;
        if (f[15:12] != 4'h5) begin
          if (m_esfd < 255) m_esfd++;
        end else if (int'(f[11:8]) != int'(MAC0) + g) begin
          if (m_edst < 255) m_edst++;
        end else if (m_q.size() < DEPTH) m_q.push_back({g[1:0], f[11:0]});
        else m_ovf = 1'b1;
      end
      for (int p = 0; p < NP; p++) begin
        if (rxv[p] && !m_prev[p]) begin
          if (m_pend[p]) m_ovf = 1'b1;
          m_pf[p]   = mon_if.rx_frame[16*p +: 16];
          m_pend[p] = 1'b1;
        end
        m_prev[p] = rxv[p];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_disp_valid", mon_if.disp_valid,   m_vis);
      chk("m_disp_port",  mon_if.disp_port,    m_disp[13:12]);
      chk("m_disp_dst",   mon_if.disp_dst,     m_disp[11:8]);
      chk("m_disp_src",   mon_if.disp_src,     m_disp[7:4]);
      chk("m_disp_pay",   mon_if.disp_payload, m_disp[3:0]);
      chk("m_log_count",  mon_if.log_count,    m_q.size());
      chk("m_overflow",   mon_if.overflow,     m_ovf);
`ifdef RX_MONITOR_ERR_CNT_EN
      chk("m_err_sfd",    mon_if.err_sfd_cnt,  m_esfd);
      chk("m_err_dst",    mon_if.err_dst_cnt,  m_edst);
`endif
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_frame(input int p, input logic [15:0] f);
    mon_if.rx_frame[16*p +: 16] = f;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mon_if.clear    = 1'b0;
    mon_if.rx_frame = '0;
    mon_if.rx_valid = '0;
    tick(2);
    chk_en = 1'b1;
    chk("rst_disp_valid", mon_if.disp_valid, 0);
    chk("rst_log_count",  mon_if.log_count,  0);
    chk("rst_overflow",   mon_if.overflow,   0);
    rst = 1'b0;
    tick(1);

    // single valid frame on port 1
    set_frame(1, 16'h5BA7);
    mon_if.rx_valid = 4'b0010;
    tick(1);
    mon_if.rx_valid = 4'b0000;
    tick(2);
    chk("t1_valid", mon_if.disp_valid,   1);
    chk("t1_port",  mon_if.disp_port,    1);
    chk("t1_dst",   mon_if.disp_dst,     4'hB);
    chk("t1_src",   mon_if.disp_src,     4'hA);
    chk("t1_pay",   mon_if.disp_payload, 4'h7);
    tick(8);
    chk("t1_hold_valid", mon_if.disp_valid, 1);
    chk("t1_hold_port",  mon_if.disp_port,  1);
    chk("t1_hold_log",   mon_if.log_count,  0);

    // same-cycle edges on ports 0,2,3
    pulse_rst();
    set_frame(0, 16'h5A12);
    set_frame(2, 16'h5C34);
    set_frame(3, 16'h5D56);
    mon_if.rx_valid = 4'b1101;
    tick(1);
    mon_if.rx_valid = 4'b0000;
    tick(2);
    chk("t2_first",     mon_if.disp_port, 0);
    tick(7);
    chk("t2_first_end", mon_if.disp_port, 0);
    tick(1);
    chk("t2_second",    mon_if.disp_port, 2);
    chk("t2_second_valid", mon_if.disp_valid, 1);
    tick(8);
    chk("t2_third",     mon_if.disp_port, 3);
    chk("t2_third_pay", mon_if.disp_payload, 4'h6);

    // rejected frames: DST mismatch then bad SFD on port 2
    pulse_rst();
    set_frame(2, 16'h5B12);
    mon_if.rx_valid = 4'b0100;
    tick(1);
    mon_if.rx_valid = 4'b0000;
    tick(1);
    set_frame(2, 16'h3C12);
    mon_if.rx_valid = 4'b0100;
    tick(1);
    mon_if.rx_valid = 4'b0000;
    tick(5);
    chk("t3_no_disp", mon_if.disp_valid, 0);
    chk("t3_no_log",  mon_if.log_count,  0);
`ifdef RX_MONITOR_ERR_CNT_EN
    chk("t3_err_dst", mon_if.err_dst_cnt, 1);
    chk("t3_err_sfd", mon_if.err_sfd_cnt, 1);
`endif

    // FIFO fill and loss while first frame shows
    pulse_rst();
    set_frame(0, 16'h5A01);
    mon_if.rx_valid = 4'b0001;
    tick(1);
    mon_if.rx_valid = 4'b0000;
    tick(2);
    chk("t4_showing", mon_if.disp_valid, 1);
    set_frame(0, 16'h5A11);
    set_frame(1, 16'h5B22);
    set_frame(2, 16'h5C33);
    set_frame(3, 16'h5D44);
    mon_if.rx_valid = 4'b1111;
    tick(1);
    mon_if.rx_valid = 4'b0000;
    tick(4);
    chk("t4_full_log", mon_if.log_count, 4);
    chk("t4_no_ovf",   mon_if.overflow,  0);
    set_frame(1, 16'h5B66);
    mon_if.rx_valid = 4'b0010;
    tick(2);
    chk("t4_log",      mon_if.log_count, 4);
    chk("t4_overflow", mon_if.overflow,  1);

    // clear mid-SHOW with three queued; an edge in the clear cycle is discarded
    tick(1);
    chk("t5_pre_log",  mon_if.log_count, 3);
    chk("t5_pre_port", mon_if.disp_port, 1);
    mon_if.clear    = 1'b1;
    set_frame(2, 16'h5C77);
    mon_if.rx_valid = 4'b0110;
    tick(1);
    mon_if.clear = 1'b0;
    chk("t5_valid", mon_if.disp_valid, 0);
    chk("t5_log",   mon_if.log_count,  0);
    chk("t5_ovf",   mon_if.overflow,   0);
    chk("t5_port",  mon_if.disp_port,  0);
    tick(4);
    chk("t5_edge_dropped", mon_if.disp_valid, 0);
    mon_if.rx_valid = 4'b0000;
    tick(1);

    // reset mid-SHOW, then a fresh capture
    set_frame(3, 16'h5D9E);
    mon_if.rx_valid = 4'b1000;
    tick(1);
    mon_if.rx_valid = 4'b0000;
    tick(4);
    chk("t6_showing", mon_if.disp_valid, 1);
    pulse_rst();
    chk("t6_valid", mon_if.disp_valid,   0);
    chk("t6_port",  mon_if.disp_port,    0);
    chk("t6_dst",   mon_if.disp_dst,     0);
    chk("t6_pay",   mon_if.disp_payload, 0);
    set_frame(0, 16'h5A3C);
    mon_if.rx_valid = 4'b0001;
    tick(1);
    mon_if.rx_valid = 4'b0000;
    tick(2);
    chk("t6_new_valid", mon_if.disp_valid,   1);
    chk("t6_new_src",   mon_if.disp_src,     4'h3);
    chk("t6_new_pay",   mon_if.disp_payload, 4'hC);
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
